// File: rtl/usb_cmd_pkg.sv
// Shared types and constants for the USB command frame parser.
// Frame layout: AA 55 cmd lenH lenL payload[len] chk (chk = mod-256 sum of cmd..payload).
package usb_cmd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_CMD,
        ST_LEN_H,
        ST_LEN_L,
        ST_PAYLOAD,
        ST_CHK,
        ST_HDR,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] ERR_CMD = 2'd0;
    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_SUM = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    localparam logic [7:0] SYNC_BYTE0 = 8'hAA;
    localparam logic [7:0] SYNC_BYTE1 = 8'h55;

    // States in which a frame is partially received and the inter-byte gap is watched.
    function automatic logic in_frame(input state_t s);
        return (s == ST_SYNC) || (s == ST_CMD) || (s == ST_LEN_H) ||
               (s == ST_LEN_L) || (s == ST_PAYLOAD) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/cmd_payload_buf.sv
// Simple dual-port payload buffer: one write port, one registered read port.
// The read register holds its value while rd_en is low so the output can stall.
module cmd_payload_buf #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else if (rd_en) begin
            rd_data <= mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/usb_cmd_parser.sv
// Byte-stream frame parser: validates sync, command range, length and checksum,
// then hands out a header followed by the buffered payload on valid/ready streams.
module usb_cmd_parser
    import usb_cmd_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter logic [7:0]  CMD_BASE    = 8'h04,
    parameter int          MAX_LEN     = 256,
    parameter int          TIMEOUT_CYC = 50000,
    localparam int         CW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          hdr_valid,
    input  logic          hdr_ready,
    output logic [CW-1:0] hdr_ch,
    output logic [15:0]   hdr_len,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          err_valid,
    output logic [1:0]    err_code,
    output logic [7:0]    drop_cnt
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int GW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    state_t        state_q;
    logic [7:0]    sum_q;
    logic [15:0]   len_q;
    logic [15:0]   idx_q;
    logic [CW-1:0] ch_q;
    logic [GW-1:0] gap_q;
    logic [15:0]   rd_idx_q;
    logic          hdr_valid_q;
    logic [CW-1:0] hdr_ch_q;
    logic [15:0]   hdr_len_q;
    logic          out_valid_q;
    logic          out_last_q;
    logic          err_valid_q;
    logic [1:0]    err_code_q;
    logic [7:0]    drop_q;

    logic          accept;
    logic          cmd_ok;
    logic [15:0]   len_full;
    logic          timeout_hit;
    logic          hdr_fire;
    logic          beat_fire;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    always_comb begin
        in_ready    = !((state_q == ST_HDR) || (state_q == ST_DRAIN));
        accept      = in_valid && in_ready;
        cmd_ok      = ({1'b0, in_data} >= {1'b0, CMD_BASE}) &&
                      ({1'b0, in_data} <  ({1'b0, CMD_BASE} + 9'(NUM_CH)));
        len_full    = {len_q[15:8], in_data};
        timeout_hit = in_frame(state_q) && !in_valid && (gap_q == GW'(TIMEOUT_CYC - 1));
        hdr_fire    = (state_q == ST_HDR) && hdr_ready && (hdr_len_q != 16'd0);
        beat_fire   = (state_q == ST_DRAIN) && out_valid_q && out_ready && !out_last_q;
        wr_en       = accept && (state_q == ST_PAYLOAD);
        // The first read is issued during the header handshake so byte 0 is ready on DRAIN entry.
        rd_en       = hdr_fire || beat_fire;
        rd_addr     = hdr_fire ? '0 : rd_idx_q[AW-1:0];
    end

    cmd_payload_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (idx_q[AW-1:0]),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (out_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sum_q       <= 8'h00;
            len_q       <= 16'h0000;
            idx_q       <= 16'h0000;
            ch_q        <= '0;
            gap_q       <= '0;
            rd_idx_q    <= 16'h0000;
            hdr_valid_q <= 1'b0;
            hdr_ch_q    <= '0;
            hdr_len_q   <= 16'h0000;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_CMD;
            drop_q      <= 8'h00;
        end else begin
            err_valid_q <= 1'b0;

            if (in_valid && !in_ready && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end

            if (!in_frame(state_q) || accept) begin
                gap_q <= '0;
            end else begin
                gap_q <= gap_q + GW'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept && (in_data == SYNC_BYTE0)) begin
                        state_q <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (accept) begin
                        if (in_data == SYNC_BYTE1) begin
                            state_q <= ST_CMD;
                            sum_q   <= 8'h00;
                            len_q   <= 16'h0000;
                        end else if (in_data != SYNC_BYTE0) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_CMD: begin
                    if (accept) begin
                        if (cmd_ok) begin
                            ch_q    <= CW'(in_data - CMD_BASE);
                            sum_q   <= sum_q + in_data;
                            state_q <= ST_LEN_H;
                        end else begin
                            err_valid_q <= 1'b1;
                            err_code_q  <= ERR_CMD;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                ST_LEN_H: begin
                    if (accept) begin
                        len_q[15:8] <= in_data;
                        sum_q       <= sum_q + in_data;
                        state_q     <= ST_LEN_L;
                    end
                end
                ST_LEN_L: begin
                    if (accept) begin
                        len_q <= len_full;
                        sum_q <= sum_q + in_data;
                        idx_q <= 16'h0000;
                        if (len_full > 16'(MAX_LEN)) begin
                            err_valid_q <= 1'b1;
                            err_code_q  <= ERR_LEN;
                            state_q     <= ST_IDLE;
                        end else if (len_full == 16'h0000) begin
                            state_q <= ST_CHK;
                        end else begin
                            state_q <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        sum_q <= sum_q + in_data;
                        if (idx_q == (len_q - 16'd1)) begin
                            state_q <= ST_CHK;
                        end else begin
                            idx_q <= idx_q + 16'd1;
                        end
                    end
                end
                ST_CHK: begin
                    if (accept) begin
                        if (in_data == sum_q) begin
                            hdr_valid_q <= 1'b1;
                            hdr_ch_q    <= ch_q;
                            hdr_len_q   <= len_q;
                            state_q     <= ST_HDR;
                        end else begin
                            err_valid_q <= 1'b1;
                            err_code_q  <= ERR_SUM;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                ST_HDR: begin
                    if (hdr_ready) begin
                        hdr_valid_q <= 1'b0;
                        if (hdr_len_q != 16'h0000) begin
                            out_valid_q <= 1'b1;
                            out_last_q  <= (hdr_len_q == 16'd1);
                            rd_idx_q    <= 16'd1;
                            state_q     <= ST_DRAIN;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_valid_q && out_ready) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            rd_idx_q   <= rd_idx_q + 16'd1;
                            out_last_q <= (rd_idx_q == (hdr_len_q - 16'd1));
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Only fires on a cycle with no byte, so it never races a byte-driven transition.
            if (timeout_hit) begin
                err_valid_q <= 1'b1;
                err_code_q  <= ERR_TMO;
                state_q     <= ST_IDLE;
            end
        end
    end

    assign hdr_valid = hdr_valid_q;
    assign hdr_ch    = hdr_ch_q;
    assign hdr_len   = hdr_len_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_usb_cmd_parser.sv
// Directed bench for usb_cmd_parser: good frames, error frames, timeout,
// back-pressure drops and reset mid-drain, checked against hand-computed values.
module tb_usb_cmd_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        hdr_valid;
    logic        hdr_ready = 1'b1;
    logic [1:0]  hdr_ch;
    logic [15:0] hdr_len;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    usb_cmd_parser #(
        .NUM_CH      (4),
        .CMD_BASE    (8'h04),
        .MAX_LEN     (256),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .hdr_valid (hdr_valid),
        .hdr_ready (hdr_ready),
        .hdr_ch    (hdr_ch),
        .hdr_len   (hdr_len),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .err_valid (err_valid),
        .err_code  (err_code),
        .drop_cnt  (drop_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Observation side: records payload beats, error pulses, header rises, stall violations.
    int         n_beats = 0;
    int         err_cnt = 0;
    int         hdr_rises = 0;
    int         stall_viol = 0;
    int         coinc = 0;
    logic [7:0] bd [64];
    logic       bl [64];
    logic       prev_hdr = 1'b0;
    logic       stall_pend = 1'b0;
    logic [7:0] stall_data = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            prev_hdr   <= 1'b0;
            stall_pend <= 1'b0;
        end else begin
            if (out_valid && out_ready && (n_beats < 64)) begin
                bd[n_beats] <= out_data;
                bl[n_beats] <= out_last;
                n_beats     <= n_beats + 1;
            end
            if (stall_pend && ((out_valid !== 1'b1) || (out_data !== stall_data))) begin
                stall_viol <= stall_viol + 1;
            end
            stall_pend <= out_valid && !out_ready;
            stall_data <= out_data;
            if (err_valid) begin
                err_cnt <= err_cnt + 1;
            end
            if (hdr_valid && !prev_hdr) begin
                hdr_rises <= hdr_rises + 1;
                if (err_valid) begin
                    coinc <= coinc + 1;
                end
            end
            prev_hdr <= hdr_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_q(input logic [7:0] q [$]);
        foreach (q[i]) begin
            send(q[i]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] frame [$];
    int base_beats;
    int base_err;
    int base_hdr;
    int k;

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle(3);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_hdr_valid", 32'(hdr_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_err_valid", 32'(err_valid), 32'd0);
        check("rst_err_code",  32'(err_code),  32'd0);
        check("rst_drop_cnt",  32'(drop_cnt),  32'd0);
        check("rst_hdr_ch",    32'(hdr_ch),    32'd0);
        check("rst_hdr_len",   32'(hdr_len),   32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        rst = 1'b0;
        idle(2);

        // One-byte frame, sum 04+00+01+50 = 55
        base_beats = n_beats;
        base_err   = err_cnt;
        frame = '{8'hAA, 8'h55, 8'h04, 8'h00, 8'h01, 8'h50, 8'h55};
        send_q(frame);
        check("t1_hdr_valid", 32'(hdr_valid), 32'd1);
        check("t1_hdr_ch",    32'(hdr_ch),    32'd0);
        check("t1_hdr_len",   32'(hdr_len),   32'd1);
        check("t1_in_ready",  32'(in_ready),  32'd0);
        idle(6);
        check("t1_beats",  32'(n_beats - base_beats), 32'd1);
        check("t1_data",   32'(bd[base_beats]),       32'h50);
        check("t1_last",   32'(bl[base_beats]),       32'd1);
        check("t1_no_err", 32'(err_cnt - base_err),   32'd0);

        // Six-byte frame drained with out_ready toggling, sum = 7F
        base_beats = n_beats;
        base_err   = err_cnt;
        frame = '{8'hAA, 8'h55, 8'h05, 8'h00, 8'h06, 8'h00, 8'h3C, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h7F};
        send_q(frame);
        check("t2_hdr_valid", 32'(hdr_valid), 32'd1);
        check("t2_hdr_ch",    32'(hdr_ch),    32'd1);
        check("t2_hdr_len",   32'(hdr_len),   32'd6);
        repeat (40) begin
            @(posedge clk);
            #1;
            out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        idle(2);
        check("t2_beats", 32'(n_beats - base_beats), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t2_data%0d", i), 32'(bd[base_beats + i]), 32'(frame[5 + i]));
            check($sformatf("t2_last%0d", i), 32'(bl[base_beats + i]), (i == 5) ? 32'd1 : 32'd0);
        end
        check("t2_no_err", 32'(err_cnt - base_err), 32'd0);

        // Same frame with a bad checksum
        base_beats = n_beats;
        base_err   = err_cnt;
        base_hdr   = hdr_rises;
        frame[11] = 8'h7E;
        send_q(frame);
        check("t3_err_valid", 32'(err_valid), 32'd1);
        check("t3_err_code",  32'(err_code),  32'd2);
        check("t3_hdr_valid", 32'(hdr_valid), 32'd0);
        idle(1);
        check("t3_err_pulse", 32'(err_valid), 32'd0);
        idle(10);
        check("t3_no_beats", 32'(n_beats - base_beats), 32'd0);
        check("t3_no_hdr",   32'(hdr_rises - base_hdr), 32'd0);
        check("t3_err_once", 32'(err_cnt - base_err),   32'd1);

        // Command out of range
        frame = '{8'hAA, 8'h55, 8'h09};
        send_q(frame);
        check("t3_cmd_valid", 32'(err_valid), 32'd1);
        check("t3_cmd_code",  32'(err_code),  32'd0);
        idle(2);

        // Length 0x0101 exceeds 256
        frame = '{8'hAA, 8'h55, 8'h04, 8'h01, 8'h01};
        send_q(frame);
        check("t3_len_valid", 32'(err_valid), 32'd1);
        check("t3_len_code",  32'(err_code),  32'd1);
        idle(2);

        // Stall after lenL: error pulse expected 100 cycles later
        frame = '{8'hAA, 8'h55, 8'h04, 8'h00, 8'h05};
        send_q(frame);
        k = 0;
        while (k < 300) begin
            @(posedge clk);
            #1;
            k++;
            if (err_valid) break;
        end
        check("t4_tmo_cycles", 32'(k),        32'd100);
        check("t4_tmo_code",   32'(err_code), 32'd3);
        idle(2);
        base_beats = n_beats;
        frame = '{8'hAA, 8'h55, 8'h04, 8'h00, 8'h01, 8'h50, 8'h55};
        send_q(frame);
        check("t4_hdr_valid", 32'(hdr_valid), 32'd1);
        check("t4_hdr_len",   32'(hdr_len),   32'd1);
        idle(6);
        check("t4_beats", 32'(n_beats - base_beats), 32'd1);
        check("t4_data",  32'(bd[base_beats]),       32'h50);

        // Header held by consumer; bytes during HDR are dropped; zero-length frame
        base_beats = n_beats;
        hdr_ready = 1'b0;
        frame = '{8'hAA, 8'hAA, 8'h55, 8'h06, 8'h00, 8'h00, 8'h06};
        send_q(frame);
        check("t5_hdr_valid", 32'(hdr_valid), 32'd1);
        check("t5_hdr_ch",    32'(hdr_ch),    32'd2);
        check("t5_in_ready",  32'(in_ready),  32'd0);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        check("t5_drop_cnt",   32'(drop_cnt),  32'd3);
        check("t5_hdr_hold",   32'(hdr_valid), 32'd1);
        check("t5_hdr_ch_st",  32'(hdr_ch),    32'd2);
        check("t5_hdr_len_st", 32'(hdr_len),   32'd0);
        hdr_ready = 1'b1;
        idle(1);
        check("t5_hdr_done",  32'(hdr_valid), 32'd0);
        check("t5_in_ready1", 32'(in_ready),  32'd1);
        idle(5);
        check("t5_no_beats", 32'(n_beats - base_beats), 32'd0);

        // Reset while a payload byte is stalled
        base_beats = n_beats;
        out_ready = 1'b0;
        frame = '{8'hAA, 8'h55, 8'h07, 8'h00, 8'h01, 8'h50, 8'h58};
        send_q(frame);
        idle(3);
        check("t6_stalled_valid", 32'(out_valid), 32'd1);
        check("t6_stalled_data",  32'(out_data),  32'h50);
        base_err = err_cnt;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_in_ready",  32'(in_ready),  32'd1);
        check("t6_err_valid", 32'(err_valid), 32'd0);
        out_ready = 1'b1;
        idle(4);
        check("t6_no_err",   32'(err_cnt - base_err),   32'd0);
        check("t6_no_beats", 32'(n_beats - base_beats), 32'd0);

        check("stall_stable", 32'(stall_viol), 32'd0);
        check("err_hdr_coincide", 32'(coinc), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_cmd_parser.md
USB_CMD_PARSER -- requirements
Module: usb_cmd_parser

Interface
REQ-001 SHALL have parameters: NUM_CH, default 4, number of command channels; CMD_BASE, default 8'h04, first command code; MAX_LEN, default 256, payload buffer depth in bytes; TIMEOUT_CYC, default 50000, maximum inter-byte gap in cycles.
REQ-002 SHALL have ports (name, direction, width, meaning), clock and reset first:
- clk in 1: single clock.
- rst in 1: reset, synchronous, active-high.
- in_data in 8: byte from USB.
- in_valid in 1: byte strobe.
- in_ready out 1: parser accepts bytes.
- hdr_valid out 1: frame header available.
- hdr_ready in 1: header consumer ready.
- hdr_ch out CW=$clog2(NUM_CH): channel, equal to cmd-CMD_BASE.
- hdr_len out 16: payload length.
- out_data out 8: payload byte.
- out_valid out 1: payload byte valid.
- out_ready in 1: payload consumer ready.
- out_last out 1: final payload byte.
- err_valid out 1: one-cycle error pulse.
- err_code out 2: 0 CMD, 1 LEN, 2 SUM, 3 TMO.
- drop_cnt out 8: bytes dropped while in_ready=0.

Function
REQ-003 SHALL parse frames of the form AA 55 cmd lenH lenL payload[len] chk, where chk is the 8-bit modulo-256 sum of cmd, lenH, lenL and all payload bytes.
REQ-004 SHALL implement states IDLE, SYNC, CMD, LEN_H, LEN_L, PAYLOAD, CHK, HDR, DRAIN.
REQ-005 IDLE: AA goes to SYNC; any other byte is ignored.
REQ-006 SYNC: 55 goes to CMD; AA stays in SYNC; any other byte goes to IDLE.
REQ-007 CMD: a cmd outside CMD_BASE..CMD_BASE+NUM_CH-1 SHALL pulse err_valid with code CMD on the next cycle and go to IDLE.
REQ-008 LEN_L: if len>MAX_LEN, SHALL pulse err LEN and go to IDLE; if len=0, SHALL go to CHK; otherwise SHALL go to PAYLOAD.
REQ-009 PAYLOAD: SHALL write each byte to the buffer at index 0..len-1 and go to CHK after the len-th byte.
REQ-010 CHK: on a match, SHALL assert hdr_valid on the cycle after the chk byte is accepted (state HDR); on a mismatch, SHALL pulse err SUM on that cycle, go to IDLE and emit no data.
REQ-011 HDR: SHALL hold hdr_valid, hdr_ch and hdr_len stable until hdr_ready; after the handshake, SHALL go to DRAIN if len>0, otherwise to IDLE.
REQ-012 DRAIN: SHALL present buffer bytes in order with valid/ready semantics and hold out_data stable while out_valid=1 and out_ready=0; SHALL assert out_last with byte len-1; SHALL go to IDLE on the handshake of the final byte.
REQ-013 The first out_valid SHALL occur no earlier than one cycle after the hdr handshake (registered buffer read).
REQ-014 in_ready SHALL be 1 in IDLE through CHK and 0 in HDR and DRAIN.
REQ-015 in_valid while in_ready=0 SHALL discard the byte and increment drop_cnt, saturating at 255.
REQ-016 In SYNC through CHK, TIMEOUT_CYC consecutive cycles without in_valid SHALL pulse err TMO and go to IDLE; any accepted byte SHALL clear the gap counter.
REQ-017 Checksum and length registers SHALL re-initialise on every entry to CMD.
REQ-018 The payload index SHALL be 16-bit and never exceed MAX_LEN-1.
REQ-019 err_valid SHALL never be asserted on the same cycle as hdr_valid rising.

Reset
REQ-020 rst SHALL, on a clk edge, force state IDLE and set in_ready=1, hdr_valid=0, out_valid=0, out_last=0, err_valid=0, err_code=0, drop_cnt=0, and hdr_ch/hdr_len/out_data=0.
REQ-021 rst asserted mid-frame or mid-drain SHALL abandon the frame with no err pulse; buffer contents are don't-care.

Structure
REQ-022 Package usb_cmd_pkg SHALL hold the state enum, err_code constants, and the sync bytes 8'hAA and 8'h55.
REQ-023 The payload buffer SHALL be sub-module cmd_payload_buf: simple dual-port RAM, depth MAX_LEN, registered read.

Verification
REQ-024 AA 55 04 00 01 50 55 -> hdr ch=0 len=1; one data beat 50 with out_last=1; no err.
REQ-025 AA 55 05 00 06 00 3C DE AD BE EF 7F with out_ready toggling every cycle -> hdr ch=1 len=6; data 00 3C DE AD BE EF in order; out_last on EF.
REQ-026 Same frame with chk 7E -> err SUM, no hdr_valid, no out_valid. AA 55 09 ... -> err CMD. AA 55 04 01 01 -> err LEN (MAX_LEN=256).
REQ-027 TIMEOUT_CYC=100: stop after lenL -> err TMO exactly 100 cycles after the last byte; the next valid frame parses correctly.
REQ-028 With hdr_ready=0, send 3 bytes -> drop_cnt=3 and hdr stable; AA AA 55 06 00 00 06 -> hdr ch=2 len=0 and no data beats.
